slc3_fetch_queue: RTL and testbench

//  Parametrised SLC-3 instruction-fetch engine with a prefetch queue. Runs the
//  MAR<-PC / PC<-PC+1 / MDR<-M[MAR] / IR<-MDR sequence against memory with

---
 rtl/slc3_fetch_queue.sv | 129 ++++++++++++
 tb/tb_slc3_fetch_queue.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc3_fetch_queue.sv
// SLC-3 instruction-fetch engine: MAR<-PC, PC<-PC+1, MDR<-M[MAR], then push
// {PC, instruction} into a prefetch FIFO for decode. Supports step mode and redirect.
module slc3_fetch_queue #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Run,
    input  logic                     Continue,
    input  logic                     step_mode,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     mem_oe,
    input  logic [DATA_W-1:0]        data_from_mem,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [DATA_W-1:0]        inst_data,
    output logic [ADDR_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [15:0]              fetch_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned WW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, CAPTURE, HOLD, PAUSE} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, mar;
    logic [DATA_W-1:0] mdr;
    logic [WW-1:0]     wait_cnt;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_n;
    logic [15:0]       fcount;
    logic              flush, push, pop, wait_last, slot_free;

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (Run) state_n = ADDR;
            ADDR:    state_n = WAIT;
            WAIT:    if (wait_last) state_n = CAPTURE;
            CAPTURE: begin
                if (step_mode)      state_n = PAUSE;
                else if (slot_free) state_n = ADDR;
                else                state_n = HOLD;
            end
            HOLD:    if (slot_free) state_n = ADDR;
            PAUSE:   if (Continue) state_n = slot_free ? ADDR : HOLD;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = ADDR;
    end

    // slot_free looks at the occupancy after this cycle's push/pop, so a
    // fetch is only launched when its CAPTURE is guaranteed a free entry.
    always_comb begin
        flush     = redirect_valid && (state != IDLE);
        mem_oe    = (state == WAIT);
        wait_last = (state == WAIT) && (wait_cnt == WW'(MEM_WAIT - 1));
        push      = (state == CAPTURE) && !flush;
        pop       = (count != '0) && inst_ready && !flush;
        count_n   = count + CW'(push) - CW'(pop);
        slot_free = count_n < CW'(DEPTH);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc       <= ADDR_W'(RESET_PC);
            mar      <= '0;
            mdr      <= '0;
            wait_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fcount   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
                q_pc[i]   <= '0;
            end
        end else begin
            if (redirect_valid)     pc <= redirect_pc;
            else if (state == ADDR) pc <= pc + ADDR_W'(1);

            if (state == ADDR && !flush) mar <= pc;

            if (state == WAIT && !flush && !wait_last) wait_cnt <= wait_cnt + WW'(1);
            else                                       wait_cnt <= '0;

            if (wait_last && !flush) mdr <= data_from_mem;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    q_data[wr_ptr] <= mdr;
                    q_pc[wr_ptr]   <= mar;
                    wr_ptr         <= wr_ptr + PW'(1);
                    fcount         <= fcount + 16'd1;
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count_n;
            end
        end
    end

    assign mem_addr    = mar;
    assign inst_valid  = (count != '0);
    assign inst_data   = q_data[rd_ptr];
    assign inst_pc     = q_pc[rd_ptr];
    assign q_count     = count;
    assign fetch_count = fcount;

endmodule

// File: tb/tb_slc3_fetch_queue.sv
// Scoreboard bench for slc3_fetch_queue: stimulus queues expected {pc, data}
// pairs, negedge monitors pop and compare whenever decode consumes an entry.
module tb_slc3_fetch_queue;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1, Reset2 = 1'b1;
    logic        Run = 1'b0, Continue = 1'b0, step_mode = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        inst_ready = 1'b0, inst_ready2 = 1'b0;

    logic [15:0] mem_addr, data_from_mem, inst_data, inst_pc, fetch_count;
    logic        mem_oe, inst_valid;
    logic [2:0]  q_count;
    logic [15:0] mem_addr2, data_from_mem2, inst_data2, inst_pc2, fetch_count2;
    logic        mem_oe2, inst_valid2;
    logic [2:0]  q_count2;

    int unsigned n_checks = 0, n_pass = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_q2[$];

    always #5 Clk = ~Clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: mem_word = 16'h1234;
            16'h0001: mem_word = 16'h5678;
            16'h0002: mem_word = 16'h9ABC;
            16'h0003: mem_word = 16'hDEF0;
            default:  mem_word = a ^ 16'hC3C3;
        endcase
    endfunction

    assign data_from_mem  = mem_word(mem_addr);
    assign data_from_mem2 = mem_word(mem_addr2);

    slc3_fetch_queue #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .MEM_WAIT(2), .RESET_PC(0)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .step_mode(step_mode),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr), .mem_oe(mem_oe), .data_from_mem(data_from_mem),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
        .inst_pc(inst_pc), .q_count(q_count), .fetch_count(fetch_count)
    );

    slc3_fetch_queue #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .MEM_WAIT(2), .RESET_PC(16'hFFFF)) dut2 (
        .Clk(Clk), .Reset(Reset2), .Run(Run), .Continue(Continue), .step_mode(step_mode),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_addr(mem_addr2), .mem_oe(mem_oe2), .data_from_mem(data_from_mem2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2), .inst_data(inst_data2),
        .inst_pc(inst_pc2), .q_count(q_count2), .fetch_count(fetch_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        else n_pass++;
    endtask

    always @(negedge Clk) begin
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got pc 0x%0h data 0x%0h, required no entry", inst_pc, inst_data);
            end else chk("pop", {inst_pc, inst_data}, exp_q.pop_front());
        end
    end

    always @(negedge Clk) begin
        if (inst_valid2 && inst_ready2) begin
            if (exp_q2.size() == 0) begin
                n_checks++;
                $display("FAIL pop2_unexpected: got pc 0x%0h data 0x%0h, required no entry", inst_pc2, inst_data2);
            end else chk("pop2", {inst_pc2, inst_data2}, exp_q2.pop_front());
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        Reset = 1'b1; inst_ready = 1'b0; step_mode = 1'b0; Run = 1'b0;
        Continue = 1'b0; redirect_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic pulse_run();
        tick(); Run = 1'b1;
        tick(); Run = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_q.push_back({pc, mem_word(pc)});
    endtask

    task automatic wait_q(input int unsigned v, input int unsigned lim, input string name);
        logic ok = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            @(negedge Clk); #1;
            if (q_count == 3'(v)) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_drain(input bit second, input int unsigned lim, input string name);
        logic ok = 1'b0;
        for (int unsigned i = 0; i < lim; i++) begin
            @(negedge Clk); #1;
            if ((second ? exp_q2.size() : exp_q.size()) == 0) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_oe_addr(input logic [15:0] addr, input string name);
        logic ok = 1'b0;
        for (int unsigned i = 0; i < 20; i++) begin
            @(negedge Clk); #1;
            if (mem_oe) begin ok = 1'b1; break; end
        end
        chk(name, {15'd0, ok, mem_addr}, {15'd0, 1'b1, addr});
    endtask

    task automatic count_oe(input int unsigned cycles, output int unsigned n, output logic [15:0] addr);
        n = 0; addr = '0;
        for (int unsigned i = 0; i < cycles; i++) begin
            @(negedge Clk); #1;
            if (mem_oe) begin n++; addr = mem_addr; end
        end
    endtask

    task automatic wait_wait_with(input int unsigned qn, input string name);
        logic ok = 1'b0;
        for (int unsigned i = 0; i < 60; i++) begin
            @(negedge Clk); #1;
            if (q_count == 3'(qn) && mem_oe) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int unsigned n, lat, gap;
        logic [15:0] a;

        // 1: latency and throughput, ready held high
        do_reset();
        chk("reset_qcount", {29'd0, q_count}, 32'd0);
        chk("reset_outs", {mem_oe, inst_valid, fetch_count, mem_addr}, 33'd0);
        exp_q.push_back({16'h0000, 16'h1234});
        exp_q.push_back({16'h0001, 16'h5678});
        exp_q.push_back({16'h0002, 16'h9ABC});
        exp_q.push_back({16'h0003, 16'hDEF0});
        inst_ready = 1'b1;
        pulse_run();
        lat = 0;
        for (int unsigned i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (inst_valid) begin lat = i; break; end
        end
        chk("first_valid_cycle", lat, 32'd5);
        gap = 0;
        for (int unsigned i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (inst_valid) begin gap = i; break; end
        end
        chk("issue_gap", gap, 32'd4);
        wait_drain(1'b0, 40, "t1_drain");
        tick(); inst_ready = 1'b0;

        // 2: back-pressure fills the queue, one pop releases exactly one fetch
        do_reset();
        for (int unsigned p = 0; p <= 8; p++) push_exp(16'(p));
        pulse_run();
        wait_q(4, 60, "t2_full");
        count_oe(8, n, a);
        chk("t2_hold_no_oe", n, 32'd0);
        chk("t2_hold_qcount", {29'd0, q_count}, 32'd4);
        tick(); inst_ready = 1'b1;
        tick(); inst_ready = 1'b0;
        count_oe(16, n, a);
        chk("t2_one_fetch_oe", n, 32'd2);
        chk("t2_fetch_addr", {16'd0, a}, 32'h0004);
        chk("t2_refill_qcount", {29'd0, q_count}, 32'd4);
        chk("t2_fetch_count", {16'd0, fetch_count}, 32'd5);
        tick(); inst_ready = 1'b1;
        wait_drain(1'b0, 80, "t2_drain");
        tick(); inst_ready = 1'b0;

        // 3: step mode, one entry per Continue
        do_reset();
        step_mode = 1'b1;
        for (int unsigned p = 0; p <= 2; p++) push_exp(16'(p));
        pulse_run();
        wait_q(1, 30, "t3_first");
        chk("t3_fc1", {16'd0, fetch_count}, 32'd1);
        count_oe(10, n, a);
        chk("t3_paused_no_oe", n, 32'd0);
        for (int unsigned k = 2; k <= 3; k++) begin
            tick(); Continue = 1'b1;
            tick(); Continue = 1'b0;
            count_oe(10, n, a);
            chk("t3_step_oe", n, 32'd2);
            chk("t3_step_qcount", {29'd0, q_count}, k);
            chk("t3_step_fc", {16'd0, fetch_count}, k);
        end
        tick(); inst_ready = 1'b1;
        wait_drain(1'b0, 20, "t3_drain");
        tick(); inst_ready = 1'b0;

        // 4: redirect during WAIT with two entries queued
        do_reset();
        pulse_run();
        wait_wait_with(2, "t4_reach_wait");
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h3000;
        push_exp(16'h3000);
        push_exp(16'h3001);
        tick(); redirect_valid = 1'b0;
        @(negedge Clk); #1;
        chk("t4_flushed", {28'd0, inst_valid, q_count}, 32'd0);
        chk("t4_no_push", {16'd0, fetch_count}, 32'd2);
        wait_oe_addr(16'h3000, "t4_new_addr");
        begin
            logic ok = 1'b0;
            for (int unsigned i = 0; i < 20; i++) begin
                @(negedge Clk); #1;
                if (inst_valid) begin ok = 1'b1; break; end
            end
            chk("t4_head_pc", {15'd0, ok, inst_pc}, {15'd0, 1'b1, 16'h3000});
        end
        tick(); inst_ready = 1'b1;
        wait_drain(1'b0, 30, "t4_drain");
        tick(); inst_ready = 1'b0;

        // 6: reset in WAIT with three queued, then restart
        do_reset();
        pulse_run();
        wait_wait_with(3, "t6_reach_wait");
        tick(); Reset = 1'b1;
        tick();
        @(negedge Clk); #1;
        chk("t6_reset_ctrl", {29'd0, mem_oe, inst_valid, (q_count != 3'd0)}, 32'd0);
        chk("t6_reset_fc_addr", {fetch_count, mem_addr}, 32'd0);
        chk("t6_reset_head", {inst_pc, inst_data}, 32'd0);
        tick(); Reset = 1'b0;
        exp_q.delete();
        push_exp(16'h0000);
        inst_ready = 1'b1;
        pulse_run();
        wait_drain(1'b0, 20, "t6_restart");
        tick(); inst_ready = 1'b0;

        // redirect in IDLE only loads PC; Run together with redirect uses new PC
        do_reset();
        tick(); redirect_valid = 1'b1; redirect_pc = 16'h0050;
        tick(); redirect_valid = 1'b0;
        count_oe(6, n, a);
        chk("idle_redirect_stays", {31'd0, (n != 0) | inst_valid}, 32'd0);
        pulse_run();
        wait_oe_addr(16'h0050, "idle_redirect_pc");
        do_reset();
        tick(); Run = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0070;
        tick(); Run = 1'b0; redirect_valid = 1'b0;
        wait_oe_addr(16'h0070, "run_redirect_pc");
        do_reset();

        // 5: RESET_PC = 0xFFFF wraps to 0x0000
        Reset = 1'b1;
        tick(); Reset2 = 1'b0; inst_ready2 = 1'b1;
        exp_q2.push_back({16'hFFFF, mem_word(16'hFFFF)});
        exp_q2.push_back({16'h0000, 16'h1234});
        pulse_run();
        wait_drain(1'b1, 30, "t5_wrap");
        tick(); inst_ready2 = 1'b0; Reset2 = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
